// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab 3 truth-table sweep sequencer.
package lab3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } lab3_state_t;

  localparam int          LAB3_NVEC   = 16;
  localparam int          LAB3_VW     = 4;
  localparam logic [15:0] LAB3_GOLDEN = 16'hEF7C;

endpackage

// File: rtl/lab3_sweep_ctrl.sv
// Drives all 16 w/x/y/z vectors into the lab 3 function, samples its output after a
// settle time and scores each result against a golden truth table.
//
//   state  | meaning
//   IDLE   | vector 0000, waiting for start; results from last sweep held
//   APPLY  | driving vector idx, counting SETTLE cycles
//   SAMPLE | vector still driven; capture and score dut_out at the closing edge
//   DONE   | one-cycle done pulse, vector back to 0000, pass resolved
module lab3_sweep_ctrl
  import lab3_pkg::*;
#(
  parameter logic [15:0] EXPECTED = LAB3_GOLDEN,
  parameter int          SETTLE   = 1
) (
  input  logic        CL2947MP_clk,
  input  logic        CL2947MP_rst,
  input  logic        CL2947MP_start,
  input  logic        CL2947MP_dut_out,
  output logic        CL2947MP_w,
  output logic        CL2947MP_x,
  output logic        CL2947MP_y,
  output logic        CL2947MP_z,
  output logic        CL2947MP_busy,
  output logic        CL2947MP_done,
  output logic        CL2947MP_pass,
  output logic [4:0]  CL2947MP_mismatch_cnt,
  output logic        CL2947MP_fail_valid,
  output logic [3:0]  CL2947MP_first_fail,
  output logic [15:0] CL2947MP_captured
);

  localparam logic [3:0]         SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [LAB3_VW-1:0] IDX_LAST    = LAB3_VW'(LAB3_NVEC - 1);

  lab3_state_t          state_q, state_d;
  logic [LAB3_VW-1:0]   idx_q, idx_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [LAB3_VW-1:0]   vec_q, vec_d;
  logic [LAB3_NVEC-1:0] cap_q, cap_d;
  logic [4:0]           mm_q, mm_d;
  logic                 fv_q, fv_d;
  logic [3:0]           ff_q, ff_d;
  logic                 pass_q, pass_d;

  always_ff @(posedge CL2947MP_clk) begin
    if (CL2947MP_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      cap_q   <= '0;
      mm_q    <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      cap_q   <= cap_d;
      mm_q    <= mm_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    mm_d    = mm_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CL2947MP_start) begin
          cap_d   = '0;
          mm_d    = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cap_d[idx_q] = CL2947MP_dut_out;
        if (CL2947MP_dut_out != EXPECTED[idx_q]) begin
          mm_d = mm_q + 5'd1;
          if (!fv_q) begin
            ff_d = idx_q;
            fv_d = 1'b1;
          end
        end
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        // mm_q already includes the vector-15 result scored at the SAMPLE edge
        pass_d  = (mm_q == 5'd0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Vector register follows the next state so it is stable across APPLY and SAMPLE
    vec_d = ((state_d == ST_APPLY) || (state_d == ST_SAMPLE)) ? idx_d : '0;
  end

  assign {CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z} = vec_q;
  assign CL2947MP_busy         = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
  assign CL2947MP_done         = (state_q == ST_DONE);
  assign CL2947MP_pass         = pass_q;
  assign CL2947MP_mismatch_cnt = mm_q;
  assign CL2947MP_fail_valid   = fv_q;
  assign CL2947MP_first_fail   = ff_q;
  assign CL2947MP_captured     = cap_q;

endmodule

// File: tb/tb_lab3_sweep_ctrl.sv
// Self-checking bench for lab3_sweep_ctrl: SETTLE=1 and SETTLE=3 instances, each fed by a
// selectable model of the lab 3 function, with per-sweep results scored from a queue.
module tb_lab3_sweep_ctrl;

  localparam logic [15:0] GOLD = 16'hEF7C;

  typedef struct {
    logic [15:0] cap;
    logic [4:0]  mm;
    logic        fv;
    logic [3:0]  ff;
    logic        pass;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  int   mode_a = 0, mode_b = 0;

  logic        a_out, a_w, a_x, a_y, a_z, a_busy, a_done, a_pass, a_fv;
  logic [4:0]  a_mm;
  logic [3:0]  a_ff;
  logic [15:0] a_cap;
  logic        b_out, b_w, b_x, b_y, b_z, b_busy, b_done, b_pass, b_fv;
  logic [4:0]  b_mm;
  logic [3:0]  b_ff;
  logic [15:0] b_cap;

  always #5 clk = ~clk;

  function automatic logic model(input int md, input logic [3:0] v);
    logic w, x, y, z, f;
    {w, x, y, z} = v;
    f = (w & ~x) | (w & z) | (~w & x & ~y) | (~x & y) | (y & ~z);
    case (md)
      1:       model = ~f;
      2:       model = (v == 4'd7) ? 1'b1 : f;
      default: model = f;
    endcase
  endfunction

  function automatic exp_t predict(input int md);
    exp_t e;
    e.cap = '0; e.mm = '0; e.fv = 1'b0; e.ff = '0;
    for (int i = 0; i < 16; i++) begin
      e.cap[i] = model(md, 4'(i));
      if (e.cap[i] != GOLD[i]) begin
        e.mm = e.mm + 5'd1;
        if (!e.fv) begin e.fv = 1'b1; e.ff = 4'(i); end
      end
    end
    e.pass = (e.mm == 5'd0);
    return e;
  endfunction

  assign a_out = model(mode_a, {a_w, a_x, a_y, a_z});
  assign b_out = model(mode_b, {b_w, b_x, b_y, b_z});

  lab3_sweep_ctrl #(.EXPECTED(16'hEF7C), .SETTLE(1)) u_a (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst), .CL2947MP_start(start_a),
    .CL2947MP_dut_out(a_out),
    .CL2947MP_w(a_w), .CL2947MP_x(a_x), .CL2947MP_y(a_y), .CL2947MP_z(a_z),
    .CL2947MP_busy(a_busy), .CL2947MP_done(a_done), .CL2947MP_pass(a_pass),
    .CL2947MP_mismatch_cnt(a_mm), .CL2947MP_fail_valid(a_fv),
    .CL2947MP_first_fail(a_ff), .CL2947MP_captured(a_cap)
  );

  lab3_sweep_ctrl #(.EXPECTED(16'hEF7C), .SETTLE(3)) u_b (
    .CL2947MP_clk(clk), .CL2947MP_rst(rst), .CL2947MP_start(start_b),
    .CL2947MP_dut_out(b_out),
    .CL2947MP_w(b_w), .CL2947MP_x(b_x), .CL2947MP_y(b_y), .CL2947MP_z(b_z),
    .CL2947MP_busy(b_busy), .CL2947MP_done(b_done), .CL2947MP_pass(b_pass),
    .CL2947MP_mismatch_cnt(b_mm), .CL2947MP_fail_valid(b_fv),
    .CL2947MP_first_fail(b_ff), .CL2947MP_captured(b_cap)
  );

  task automatic check_a_reset(input string tag);
    n_checks++;
    if ({a_w, a_x, a_y, a_z, a_busy, a_done, a_pass, a_mm, a_fv, a_ff, a_cap} !== 35'd0) begin
      n_fail++;
      $display("FAIL %s_a: vec=%b busy=%b done=%b pass=%b mm=%0d fv=%b ff=%0d cap=%h, required all zero",
               tag, {a_w, a_x, a_y, a_z}, a_busy, a_done, a_pass, a_mm, a_fv, a_ff, a_cap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_a_reset("reset");
    n_checks++;
    if ({b_w, b_x, b_y, b_z, b_busy, b_done, b_pass, b_mm, b_fv, b_ff, b_cap} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_b: busy=%b done=%b mm=%0d cap=%h, required all zero", b_busy, b_done, b_mm, b_cap);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One SETTLE=1 sweep on instance A. poke_n > 0 raises start during that busy cycle.
  task automatic run_sweep_a(input string tag, input int md, input int poke_n);
    exp_t e;
    int   idx;
    mode_a = md;
    sb_q.push_back(predict(md));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      idx = (n - 1) / 2;
      n_checks++;
      if (a_busy !== (n <= 32) || a_done !== (n == 33)) begin
        n_fail++;
        $display("FAIL %s_timing: cycle %0d busy=%b done=%b, required busy=%b done=%b",
                 tag, n, a_busy, a_done, (n <= 32), (n == 33));
      end
      if (n <= 32) begin
        n_checks++;
        if ({a_w, a_x, a_y, a_z} !== 4'(idx)) begin
          n_fail++;
          $display("FAIL %s_vec: cycle %0d vec=%0d, required %0d", tag, n, {a_w, a_x, a_y, a_z}, idx);
        end
      end
      start_a = (n == poke_n);
      if (n < 34) @(negedge clk);
    end
    start_a = 1'b0;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s_sb: queue empty, required one entry", tag);
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (a_cap !== e.cap || a_mm !== e.mm || a_fv !== e.fv || a_ff !== e.ff || a_pass !== e.pass) begin
        n_fail++;
        $display("FAIL %s_result: cap=%h mm=%0d fv=%b ff=%0d pass=%b, required cap=%h mm=%0d fv=%b ff=%0d pass=%b",
                 tag, a_cap, a_mm, a_fv, a_ff, a_pass, e.cap, e.mm, e.fv, e.ff, e.pass);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_correct();  run_sweep_a("correct",  0, 0); endtask
  task automatic test_inverted(); run_sweep_a("inverted", 1, 0); endtask
  task automatic test_vec7();     run_sweep_a("vec7",     2, 0); endtask
  task automatic test_start_while_busy(); run_sweep_a("busy_start", 0, 9); endtask

  task automatic test_reset_mid_sweep();
    int dones;
    mode_a = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (18) @(negedge clk);
    n_checks++;
    if ({a_w, a_x, a_y, a_z} !== 4'd9) begin
      n_fail++;
      $display("FAIL midreset_pre: vec=%0d, required 9", {a_w, a_x, a_y, a_z});
    end
    rst = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    check_a_reset("midreset");
    rst = 1'b0;
    start_a = 1'b0;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_done === 1'b1 || a_busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: %0d cycles with done/busy after reset, required 0", dones);
    end
    run_sweep_a("post_reset", 0, 0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   dones, busy_cnt;
    bit   seen;
    mode_b = 0;
    sb_q.push_back(predict(0));
    start_b = 1'b1;
    dones = 0; busy_cnt = 0;
    @(negedge clk);
    for (int n = 1; n <= 67; n++) begin
      if (b_busy === 1'b1 && n <= 66) busy_cnt++;
      if (b_done === 1'b1) dones++;
      if (n <= 64) begin
        n_checks++;
        if ({b_w, b_x, b_y, b_z} !== 4'((n - 1) / 4)) begin
          n_fail++;
          $display("FAIL hold_vec: cycle %0d vec=%0d, required %0d", n, {b_w, b_x, b_y, b_z}, (n - 1) / 4);
        end
      end
      if (n == 66) begin
        n_checks++;
        if (b_busy !== 1'b0 || b_done !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_idle: busy=%b done=%b in cycle 66, required 0 0", b_busy, b_done);
        end
        e = sb_q.pop_front();
        n_checks++;
        if (b_cap !== e.cap || b_mm !== e.mm || b_pass !== e.pass || b_fv !== e.fv) begin
          n_fail++;
          $display("FAIL hold_result: cap=%h mm=%0d pass=%b fv=%b, required cap=%h mm=%0d pass=%b fv=%b",
                   b_cap, b_mm, b_pass, b_fv, e.cap, e.mm, e.pass, e.fv);
        end
      end
      if (n == 67) begin
        n_checks++;
        if (b_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_restart: busy=%b in cycle 67, required 1", b_busy);
        end
      end
      if (n < 67) @(negedge clk);
    end
    n_checks++;
    if (busy_cnt != 64 || dones != 1) begin
      n_fail++;
      $display("FAIL hold_counts: busy cycles=%0d dones=%0d, required 64 and 1", busy_cnt, dones);
    end
    start_b = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      if (b_done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL hold_second_done: no done within 80 cycles, required one");
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_correct();
    test_inverted();
    test_vec7();
    test_back_to_back();
    test_reset_mid_sweep();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab3_sweep_ctrl.md
# lab3_sweep_ctrl

Sequencer that exhaustively drives the 4-input lab 3 combinational function through all 16 input combinations, samples its output after a programmable settle time, and compares each result against a golden truth table. It sits beside the combinational block in the lab 3 top level: it owns the block's `w/x/y/z` inputs and observes its single output. It reports the captured truth table, the mismatch count and the first failing vector.

## Interface
- `EXPECTED`, default 16'hEF7C: golden truth table, bit `i` = required output for vector `i`. 16'hEF7C is `(wx')+(wz)+(w'xy')+(x'y)+(yz')`.
- `SETTLE`, default 1: number of drive cycles per vector before sampling; legal range 1..15.

Ports:
- `CL2947MP_clk` in 1: single clock, rising edge.
- `CL2947MP_rst` in 1: synchronous, active-high reset.
- `CL2947MP_start` in 1: request a sweep; sampled only in IDLE.
- `CL2947MP_dut_out` in 1: output of the function under test.
- `CL2947MP_w`, `CL2947MP_x`, `CL2947MP_y`, `CL2947MP_z` out 1 each: drive vector, `{w,x,y,z}` = index, `w` = MSB.
- `CL2947MP_busy` out 1: high in APPLY/SAMPLE.
- `CL2947MP_done` out 1: one-cycle pulse at sweep end.
- `CL2947MP_pass` out 1: last sweep had zero mismatches.
- `CL2947MP_mismatch_cnt` out 5: mismatches in last sweep (0..16).
- `CL2947MP_fail_valid` out 1: at least one mismatch recorded.
- `CL2947MP_first_fail` out 4: lowest failing index; 0 when `fail_valid`=0.
- `CL2947MP_captured` out 16: observed truth table, bit `i` = sampled output for vector `i`.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE: drive vector 0000. `start`=1 clears `captured`, `mismatch_cnt`, `fail_valid`, `first_fail`, `pass`. Sets idx=0 and settle counter=0, then goes to APPLY.
- APPLY: drive vector `idx` for `SETTLE` cycles. The counter increments and the FSM moves to SAMPLE when counter = `SETTLE`-1.
- SAMPLE: the vector is still driven. At the clock edge ending this cycle:
  - `captured[idx]` <= `dut_out`.
  - If `dut_out` != `EXPECTED[idx]`: increment `mismatch_cnt`. If `fail_valid`=0, also set `first_fail`=idx and `fail_valid`=1.
  - If idx=15, go to DONE; otherwise idx++, counter=0, go back to APPLY.
- DONE: one cycle. `done`=1, vector back to 0000. `pass` <= (final `mismatch_cnt`==0), computed including the idx-15 result. Then go to IDLE.
- Results (`pass`, count, `first_fail`, `captured`) hold from DONE until the next accepted start.
- `start` during APPLY/SAMPLE/DONE is ignored; there is no queuing.
- `mismatch_cnt` saturates at 16 by construction and needs no wrap handling.

## Timing
- Reset values: FSM in IDLE, vector 0000, `busy`=0, `done`=0, `pass`=0, `mismatch_cnt`=0, `fail_valid`=0, `first_fail`=0, `captured`=16'h0000.
- Reset asserted mid-sweep: the next edge forces all reset values. The partial results are discarded and `done` does not pulse.
- Reset and start in the same cycle: reset wins.
- Start accepted at edge E0: `busy` rises in the cycle after E0. Each vector occupies `SETTLE`+1 cycles, so `busy` stays high for 16·(`SETTLE`+1) cycles. `done` is high in the next cycle.
- Default `SETTLE`=1: 32 busy cycles, `done` in cycle 33 after E0. `start` is accepted again in cycle 34.
- Vector outputs are registered, so they change only on clock edges and are stable throughout APPLY and SAMPLE.

## Structure
- Shared package `lab3_pkg`:
  - FSM state enum (IDLE/APPLY/SAMPLE/DONE).
  - `LAB3_NVEC`=16 and `LAB3_VW`=4.
  - `LAB3_GOLDEN`=16'hEF7C.
- Single flat module with no sub-module.
- The function under test is instantiated by the top level or the bench, not inside this block.

## Test plan
- Correct SOP model, `SETTLE`=1, pulse start → `done` in cycle 33; `pass`=1, `mismatch_cnt`=0, `fail_valid`=0, `captured`=16'hEF7C.
- Inverted (NOR-output) model → `pass`=0, `mismatch_cnt`=16, `first_fail`=0, `captured`=16'h1083.
- Model forced to 1 only for vector 7, else correct → `mismatch_cnt`=1, `first_fail`=7, `captured`=16'hEFFC.
- `SETTLE`=3, start, then hold start high throughout → exactly one sweep, 64 busy cycles; each vector stable for 4 cycles; `done` pulses once and a second sweep begins only after return to IDLE.
- Assert reset at vector 9 of a sweep → next cycle all outputs at reset values and no `done`. A new start then produces a full, correct sweep.
- Start while busy at vector 4 → ignored; the sweep's results and timing are identical to an undisturbed run.
